// File: rtl/ripple_count_sampler.sv
// Samples an asynchronous ripple-counter bus into the clk domain and waits for it to settle.
// Presents a settled snapshot and the modular delta from the previous snapshot over valid/ready.
module ripple_count_sampler #(
  parameter int SIZE          = 8,
  parameter int STABLE_CYCLES = 2,
  parameter int MAX_TRIES     = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [SIZE-1:0] value_in,
  input  logic            sample_req,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] count,
  output logic [SIZE-1:0] delta,
  output logic            timeout
);

  localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int TW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TRIES_LAST  = TW'(MAX_TRIES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, COMPARE, HOLD} state_t;

  state_t          state_reg, state_next;
  logic [SIZE-1:0] s1, s2;
  logic [SIZE-1:0] prev, last_count;
  logic            settle_cnt;
  logic [SW-1:0]   stable_cnt;
  logic [TW-1:0]   tries;

  logic            match, stable_done, force_acc, accept;
  logic [SIZE-1:0] accept_value;

  assign match        = (s2 == prev);
  assign stable_done  = match && (stable_cnt == STABLE_LAST);
  assign force_acc    = !match && (tries == TRIES_LAST);
  assign accept       = (state_reg == COMPARE) && (stable_done || force_acc);
  // A forced accept takes the freshest synchronized sample, not the stale prev.
  assign accept_value = match ? prev : s2;

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (sample_req) state_next = SETTLE;
      SETTLE:  if (settle_cnt) state_next = COMPARE;
      COMPARE: if (accept)     state_next = HOLD;
      HOLD:    if (out_ready)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_reg != IDLE);
    out_valid = (state_reg == HOLD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1         <= '0;
      s2         <= '0;
      prev       <= '0;
      last_count <= '0;
      count      <= '0;
      delta      <= '0;
      timeout    <= 1'b0;
      settle_cnt <= 1'b0;
      stable_cnt <= '0;
      tries      <= '0;
    end else begin
      s1 <= value_in;
      s2 <= s1;
      case (state_reg)
        IDLE: begin
          if (sample_req) begin
            settle_cnt <= 1'b0;
            stable_cnt <= '0;
            tries      <= '0;
          end
        end
        SETTLE: begin
          settle_cnt <= settle_cnt + 1'b1;
          if (settle_cnt) prev <= s2;
        end
        COMPARE: begin
          if (match) begin
            if (!stable_done) stable_cnt <= stable_cnt + 1'b1;
          end else begin
            prev       <= s2;
            stable_cnt <= '0;
            tries      <= tries + 1'b1;
          end
          if (accept) begin
            count      <= accept_value;
            delta      <= accept_value - last_count;
            last_count <= accept_value;
            timeout    <= force_acc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
